// File: rtl/led_level_meter.sv
// LED bar-graph level meter: priority-encoded sample level with attack/decay ballistics.
// Optional peak-hold dot is enabled by defining LED_PEAK_HOLD_EN.
module led_level_meter #(
    parameter int NUM_LEDS     = 8,
    parameter int DECAY_CYCLES = 4,
    parameter int HOLD_CYCLES  = 8,
    localparam int LW          = $clog2(NUM_LEDS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [NUM_LEDS-1:0] sample,
    input  logic                dot_mode,
    output logic [NUM_LEDS-1:0] led,
    output logic [LW-1:0]       bar_level,
    output logic [LW-1:0]       peak_level
);

    localparam int DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DECAY_CYCLES - 1);
    localparam logic [LW:0]   NL        = (LW + 1)'(NUM_LEDS);

    function automatic logic [LW-1:0] encode_level(input logic [NUM_LEDS-1:0] s);
        logic [LW-1:0] lvl;
        lvl = {LW{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (s[i]) lvl = LW'(i + 1);
            else      lvl = lvl;
        end
        return lvl;
    endfunction

    logic [LW-1:0] new_lvl_s;
    logic [LW-1:0] bar_r, bar_nxt_s;
    logic [DW-1:0] dcnt_r, dcnt_nxt_s;
    logic [NUM_LEDS-1:0] led_s;

    // Bar state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_r  <= {LW{1'b0}};
            dcnt_r <= {DW{1'b0}};
        end else begin
            bar_r  <= bar_nxt_s;
            dcnt_r <= dcnt_nxt_s;
        end
    end

    // Bar next state: attack on equal-or-higher sample, otherwise timed decay toward zero
    always_comb begin
        new_lvl_s  = encode_level(sample);
        bar_nxt_s  = bar_r;
        dcnt_nxt_s = dcnt_r;
        if (sample_valid && (new_lvl_s >= bar_r)) begin
            bar_nxt_s  = new_lvl_s;
            dcnt_nxt_s = {DW{1'b0}};
        end else if (bar_r == {LW{1'b0}}) begin
            dcnt_nxt_s = {DW{1'b0}};
        end else if (dcnt_r == DCNT_LAST) begin
            bar_nxt_s  = bar_r - LW'(1);
            dcnt_nxt_s = {DW{1'b0}};
        end else begin
            dcnt_nxt_s = dcnt_r + DW'(1);
        end
    end

`ifdef LED_PEAK_HOLD_EN
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);

    logic [LW-1:0] peak_r, peak_nxt_s;
    logic [HW-1:0] hold_r, hold_nxt_s;
    logic [DW-1:0] pdcnt_r, pdcnt_nxt_s;

    // Peak state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_r  <= {LW{1'b0}};
            hold_r  <= {HW{1'b0}};
            pdcnt_r <= {DW{1'b0}};
        end else begin
            peak_r  <= peak_nxt_s;
            hold_r  <= hold_nxt_s;
            pdcnt_r <= pdcnt_nxt_s;
        end
    end

    // Peak next state: capture beats hold beats decay; decay only while above the bar
    always_comb begin
        peak_nxt_s  = peak_r;
        hold_nxt_s  = hold_r;
        pdcnt_nxt_s = pdcnt_r;
        if (sample_valid && (new_lvl_s >= peak_r)) begin
            peak_nxt_s  = new_lvl_s;
            hold_nxt_s  = HOLD_INIT;
            pdcnt_nxt_s = {DW{1'b0}};
        end else if (hold_r != {HW{1'b0}}) begin
            hold_nxt_s = hold_r - HW'(1);
        end else if (peak_r > bar_r) begin
            if (pdcnt_r == DCNT_LAST) begin
                peak_nxt_s  = peak_r - LW'(1);
                pdcnt_nxt_s = {DW{1'b0}};
            end else begin
                pdcnt_nxt_s = pdcnt_r + DW'(1);
            end
        end else begin
            pdcnt_nxt_s = {DW{1'b0}};
        end
    end

    assign peak_level = peak_r;
`else
    assign peak_level = {LW{1'b0}};
`endif

    // LED decode: bar anchored at the MSB, dot_mode acts immediately, peak dot OR-ed on top
    always_comb begin
        led_s = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (dot_mode) begin
                led_s[i] = (bar_r != {LW{1'b0}}) && (((LW + 1)'(i) + {1'b0, bar_r}) == NL);
            end else begin
                led_s[i] = (((LW + 1)'(i) + {1'b0, bar_r}) >= NL);
            end
            led_s[i] = led_s[i] | ((peak_level != {LW{1'b0}}) &&
                                   (((LW + 1)'(i) + {1'b0, peak_level}) == NL));
        end
    end

    assign led       = led_s;
    assign bar_level = bar_r;

endmodule
